wb_stage: RTL and testbench

Registered write-back stage for the 5-stage pipeline, successor to the combinational WB. It latches the MEM->WB bus under a valid/allow-in handshake, retires up to `LANES` instructions per cycle into the register file, and resolves same-destination collisions between lanes. It also publishes hazard destinations and per-lane retire traces, and keeps a 64-bit retired-instruction counter. It sits between the MEM stage and the register file and hazard unit.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/wb_lane_merge.sv | 25 ++
 rtl/wb_stage.sv | 114 +++++++++++
 tb/tb_wb_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: MEM->WB lane layout and helpers.
// Lane fields, MSB->LSB: lane_v, dest, we, result, dm_addr, pc.
package cpu_pkg;

  function automatic int lane_w(input int xlen);
    return 7 + 3 * xlen;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return 0;
  endfunction

  function automatic int dm_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int res_lsb(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int we_bit(input int xlen);
    return 3 * xlen;
  endfunction

  function automatic int dest_lsb(input int xlen);
    return 3 * xlen + 1;
  endfunction

  function automatic int v_bit(input int xlen);
    return 3 * xlen + 6;
  endfunction

  localparam int LANE_W = 7 + 3 * 32;

  function automatic logic [2:0] popcount(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/wb_lane_merge.sv
// Same-destination collision kill between retire lanes.
// A lane loses when any higher-index lane writes the same register.
module wb_lane_merge
  import cpu_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic [LANES-1:0]   rf_we_raw,
  input  logic [LANES*5-1:0] dest,
  output logic [LANES-1:0]   killed
);

  // Highest-index writer of a register wins.
  always_comb begin
    killed = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int k = j + 1; k < LANES; k++) begin
        if (rf_we_raw[j] && rf_we_raw[k] &&
            dest[j*5 +: 5] == dest[k*5 +: 5])
          killed[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: latches MEM->WB, retires lanes,
// publishes hazard dests, retire trace and instret.
module wb_stage
  import cpu_pkg::*;
#(
  parameter  int LANES  = 1,
  parameter  int XLEN   = 32,
  localparam int LANE_W = lane_w(XLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid_i,
  input  logic [LANES*LANE_W-1:0] mem2wb_bus_i,
  output logic                    wb_allowin_o,
  input  logic                    hold_i,
  output logic [LANES-1:0]        rf_we_o,
  output logic [LANES*5-1:0]      rf_wdest_o,
  output logic [LANES*XLEN-1:0]   rf_wdata_o,
  output logic [LANES*5-1:0]      ctl_wb_dest_o,
  output logic                    ctl_wb_over_o,
  output logic [LANES-1:0]        retire_v_o,
  output logic [LANES*XLEN-1:0]   retire_pc_o,
  output logic [LANES*XLEN-1:0]   retire_dm_addr_o,
  output logic [63:0]             instret_o
);

  localparam int PC_L = pc_lsb(XLEN);
  localparam int DM_L = dm_lsb(XLEN);
  localparam int RS_L = res_lsb(XLEN);
  localparam int WE_B = we_bit(XLEN);
  localparam int DS_L = dest_lsb(XLEN);
  localparam int V_B  = v_bit(XLEN);

  logic                    wb_valid;
  logic [LANES*LANE_W-1:0] payload;
  logic                    wb_over;
  logic [LANES-1:0]        lane_live;
  logic [LANES-1:0]        lane_we;
  logic [LANES-1:0]        rf_we_raw;
  logic [LANES-1:0]        killed;
  logic [LANES*5-1:0]      dest;
  logic [3:0]              rv4;
  logic [63:0]             instret;

  assign wb_over       = wb_valid & ~hold_i;
  assign wb_allowin_o  = ~wb_valid | wb_over;
  assign ctl_wb_over_o = wb_over;
  assign instret_o     = instret;

  // Bundle register: load beats drain; payload kept on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
    end else if (mem_valid_i && wb_allowin_o) begin
      wb_valid <= 1'b1;
      payload  <= mem2wb_bus_i;
    end else if (wb_over) begin
      wb_valid <= 1'b0;
    end
  end

  // Unpack lanes and form raw writes, hazard dests and trace.
  always_comb begin
    lane_live        = '0;
    lane_we          = '0;
    rf_we_raw        = '0;
    dest             = '0;
    rf_wdata_o       = '0;
    retire_pc_o      = '0;
    retire_dm_addr_o = '0;
    ctl_wb_dest_o    = '0;
    retire_v_o       = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_live[k] = wb_valid & payload[k*LANE_W + V_B];
      lane_we[k]   = payload[k*LANE_W + WE_B];
      dest[k*5 +: 5] = payload[k*LANE_W + DS_L +: 5];
      rf_wdata_o[k*XLEN +: XLEN] =
        payload[k*LANE_W + RS_L +: XLEN];
      retire_pc_o[k*XLEN +: XLEN] =
        payload[k*LANE_W + PC_L +: XLEN];
      retire_dm_addr_o[k*XLEN +: XLEN] =
        payload[k*LANE_W + DM_L +: XLEN];
      rf_we_raw[k] = lane_live[k] & lane_we[k] &
                     (dest[k*5 +: 5] != 5'd0);
      if (lane_live[k] && lane_we[k])
        ctl_wb_dest_o[k*5 +: 5] = dest[k*5 +: 5];
      retire_v_o[k] = lane_live[k] & wb_over;
    end
  end

  assign rf_wdest_o = dest;
  assign rf_we_o    = rf_we_raw & ~killed & {LANES{wb_over}};

  wb_lane_merge #(.LANES(LANES)) u_merge (
    .rf_we_raw (rf_we_raw),
    .dest      (dest),
    .killed    (killed)
  );

  // Zero-extend the retire vector for the shared popcount.
  always_comb begin
    rv4 = '0;
    rv4[LANES-1:0] = retire_v_o;
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst)
      instret <= '0;
    else
      instret <= instret + {61'd0, popcount(rv4)};
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with two lanes.
// Hand-computed expectations plus a tiny register-file model.
module tb_wb_stage;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int LW    = 7 + 3 * XLEN;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mem_valid;
  logic [LANES*LW-1:0]   bus;
  logic                  allowin;
  logic                  hold;
  logic [LANES-1:0]      rf_we;
  logic [LANES*5-1:0]    rf_wdest;
  logic [LANES*XLEN-1:0] rf_wdata;
  logic [LANES*5-1:0]    ctl_dest;
  logic                  ctl_over;
  logic [LANES-1:0]      ret_v;
  logic [LANES*XLEN-1:0] ret_pc;
  logic [LANES*XLEN-1:0] ret_dm;
  logic [63:0]           instret;

  int checks = 0;
  int failures = 0;
  int writes_x9 = 0;
  int total_writes = 0;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  wb_stage #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid_i      (mem_valid),
    .mem2wb_bus_i     (bus),
    .wb_allowin_o     (allowin),
    .hold_i           (hold),
    .rf_we_o          (rf_we),
    .rf_wdest_o       (rf_wdest),
    .rf_wdata_o       (rf_wdata),
    .ctl_wb_dest_o    (ctl_dest),
    .ctl_wb_over_o    (ctl_over),
    .retire_v_o       (ret_v),
    .retire_pc_o      (ret_pc),
    .retire_dm_addr_o (ret_dm),
    .instret_o        (instret)
  );

  always @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (rf_we[k]) begin
        regs[rf_wdest[k*5 +: 5]] = rf_wdata[k*XLEN +: XLEN];
        total_writes++;
        if (rf_wdest[k*5 +: 5] == 5'd9) writes_x9++;
      end
    end
  end

  function automatic logic [LW-1:0] ln(
    input logic v, input logic [4:0] d, input logic we,
    input logic [31:0] res, input logic [31:0] dm,
    input logic [31:0] pc);
    return {v, d, we, res, dm, pc};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1'b1;
    hold = 1'b0;
    mem_valid = 1'b1;
    bus = {ln(1, 5'd7, 1, 32'h1, 0, 0), ln(1, 5'd8, 1, 32'h2, 0, 0)};
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_we", rf_we, 2'b00);
      chk("rst_instret", instret, 0);
      chk("rst_allowin", allowin, 1);
      chk("rst_over", ctl_over, 0);
      chk("rst_dest", ctl_dest, 0);
    end
    rst = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk("rst_nowrite", total_writes, 0);

    bus = {ln(0, 5'd0, 0, 0, 0, 0),
           ln(1, 5'd5, 1, 32'hDEADBEEF, 32'h100, 32'h1C000000)};
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("s_we", rf_we, 2'b01);
    chk("s_dest", rf_wdest[4:0], 5);
    chk("s_data", rf_wdata[31:0], 32'hDEADBEEF);
    chk("s_pc", ret_pc[31:0], 32'h1C000000);
    chk("s_dm", ret_dm[31:0], 32'h100);
    chk("s_retv", ret_v, 2'b01);
    chk("s_hdest", ctl_dest, {5'd0, 5'd5});
    chk("s_inst0", instret, 0);
    tick();
    chk("s_inst1", instret, 1);
    chk("s_idle_we", rf_we, 0);
    chk("s_x5", regs[5], 32'hDEADBEEF);

    bus = {ln(0, 5'd0, 0, 0, 0, 0), ln(1, 5'd0, 1, 32'h55, 0, 4)};
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("x0_we", rf_we, 0);
    chk("x0_hdest", ctl_dest, 0);
    chk("x0_retv", ret_v, 2'b01);
    tick();
    chk("x0_inst", instret, 2);
    chk("x0_reg", regs[0], 0);

    bus = {ln(1, 5'd3, 1, 32'h22, 0, 8), ln(1, 5'd3, 1, 32'h11, 0, 4)};
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("col_we", rf_we, 2'b10);
    chk("col_data", rf_wdata[63:32], 32'h22);
    tick();
    chk("col_x3", regs[3], 32'h22);
    chk("col_inst", instret, 4);

    bus = {ln(1, 5'd10, 0, 32'hA, 0, 8), ln(1, 5'd9, 1, 32'h99, 0, 4)};
    mem_valid = 1'b1;
    tick();
    hold = 1'b1;
    bus = {ln(1, 5'd13, 1, 32'hD, 0, 8), ln(1, 5'd12, 1, 32'hC, 0, 4)};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("h_allowin", allowin, 0);
      chk("h_we", rf_we, 0);
      chk("h_dest", ctl_dest, {5'd0, 5'd9});
      chk("h_over", ctl_over, 0);
      tick();
    end
    chk("h_x9_none", writes_x9, 0);
    chk("h_inst", instret, 4);
    hold = 1'b0;
    #1;
    chk("h_rel_allowin", allowin, 1);
    chk("h_rel_we", rf_we, 2'b01);
    tick();
    mem_valid = 1'b0;
    chk("h_x9_once", writes_x9, 1);
    chk("h_next_dest", rf_wdest, {5'd13, 5'd12});
    chk("h_next_we", rf_we, 2'b11);
    chk("h_inst2", instret, 6);
    tick();
    chk("h_inst3", instret, 8);
    chk("h_x9_val", regs[9], 32'h99);

    begin
      int overs = 0;
      mem_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bus = {ln(1, 5'(16 + i), 1, 32'(i), 0, 32'(8 * i + 4)),
               ln(1, 5'(1 + i), 1, 32'(i), 0, 32'(8 * i))};
        tick();
        if (ctl_over) overs++;
      end
      mem_valid = 1'b0;
      chk("b2b_over", overs, 8);
      tick();
      chk("b2b_inst", instret, 24);
      chk("b2b_x23", regs[23], 32'd7);
    end

    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret;
    bus = {ln(1, 5'd20, 1, 1, 0, 0), ln(1, 5'd21, 1, 2, 0, 0)};
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("wrap_zero", instret, 0);
    tick();
    chk("wrap_idle", instret, 0);

    bus = {ln(1, 5'd9, 1, 32'h77, 0, 0), ln(1, 5'd9, 1, 32'h66, 0, 0)};
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    hold = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rh_we", rf_we, 0);
    tick();
    rst = 1'b0;
    hold = 1'b0;
    #1;
    chk("rh_retv", ret_v, 0);
    chk("rh_inst", instret, 0);
    chk("rh_dest", ctl_dest, 0);
    tick();
    chk("rh_x9", regs[9], 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
